// File: rtl/alu_seq.sv
// Handshaked W-bit ALU: single-cycle arithmetic/logic ops plus a shift-add multiply,
// with the result and Z/N/C/V flags held in an output register until the consumer takes them.
module alu_seq #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W) + 1
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   CTR,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] O,
  output logic         Z,
  output logic         N,
  output logic         C,
  output logic         V,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // valid must not depend on ready, and data is only sampled on the transfer edge.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MULT = 2'd2} state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADC = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;

  state_t          state;
  logic [W-1:0]    ina, inb, mp;
  logic [3:0]      op;
  logic [2*W-1:0]  acc, mc, acc_step;
  logic [CW-1:0]   cnt;
  logic            cst;

  logic [W:0]      add_w, sub_w;
  logic [W-1:0]    alu_res, fin_res;
  logic            alu_c, alu_v, alu_zok;
  logic            fin_c, fin_v, fin_zok;
  logic            load;

  assign in_ready  = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign dbg_state = state;
  assign acc_step  = mp[0] ? acc + mc : acc;

  always_comb begin
    add_w   = {1'b0, ina} + {1'b0, inb} + {{W{1'b0}}, (op == OP_ADC) & cst};
    sub_w   = {1'b0, ina} - {1'b0, inb};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_zok = 1'b1;
    case (op)
      4'b0000, 4'b0010: begin
        alu_res = add_w[W-1:0];
        alu_c   = add_w[W];
        alu_v   = (ina[W-1] == inb[W-1]) && (add_w[W-1] != ina[W-1]);
      end
      4'b0001: begin
        alu_res = sub_w[W-1:0];
        alu_c   = sub_w[W];
        alu_v   = (ina[W-1] != inb[W-1]) && (sub_w[W-1] != ina[W-1]);
      end
      4'b1000: alu_res = ina & inb;
      4'b1001: alu_res = ina | inb;
      4'b1010: alu_res = ina ^ inb;
      4'b1011: alu_res = ~ina;
      4'b1100: begin alu_res = {1'b0, ina[W-1:1]};      alu_c = ina[0];   end
      4'b1101: begin alu_res = {ina[W-2:0], 1'b0};      alu_c = ina[W-1]; end
      4'b1110: begin alu_res = {ina[0], ina[W-1:1]};    alu_c = ina[0];   end
      4'b1111: begin alu_res = {ina[W-2:0], ina[W-1]};  alu_c = ina[W-1]; end
      // Reserved opcodes complete with a zero result and every flag clear, Z included.
      default: alu_zok = 1'b0;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    fin_res = alu_res;
    fin_c   = alu_c;
    fin_v   = alu_v;
    fin_zok = alu_zok;
    if (state == EXEC && op != OP_MUL) begin
      load = 1'b1;
    end else if (state == MULT && cnt == CW'(1)) begin
      load    = 1'b1;
      fin_res = acc_step[W-1:0];
      fin_c   = |acc_step[2*W-1:W];
      fin_v   = 1'b0;
      fin_zok = 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state     <= IDLE;
      ina       <= '0;
      inb       <= '0;
      op        <= '0;
      acc       <= '0;
      mc        <= '0;
      mp        <= '0;
      cnt       <= '0;
      cst       <= 1'b0;
      O         <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ina   <= A;
            inb   <= B;
            op    <= CTR;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (op == OP_MUL) begin
            acc   <= '0;
            mc    <= {{W{1'b0}}, ina};
            mp    <= inb;
            cnt   <= CW'(W);
            state <= MULT;
          end else begin
            state <= IDLE;
          end
        end
        MULT: begin
          acc <= acc_step;
          mc  <= mc << 1;
          mp  <= mp >> 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A load on the same edge as a drain wins, so no result is ever dropped.
      if (load) begin
        O         <= fin_res;
        Z         <= fin_zok && (fin_res == '0);
        N         <= fin_res[W-1];
        C         <= fin_c;
        V         <= fin_v;
        cst       <= fin_c;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=8): hand-computed results, flags {Z,N,C,V} and latencies.
module tb_alu_seq;

  localparam int W = 8;

  logic         ck = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic [3:0]   CTR;
  logic         in_valid, in_ready;
  logic [W-1:0] O;
  logic         Z, N, C, V;
  logic         out_valid, out_ready;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.W(W)) dut (
    .ck(ck), .rst_n(rst_n), .A(A), .B(B), .CTR(CTR),
    .in_valid(in_valid), .in_ready(in_ready),
    .O(O), .Z(Z), .N(N), .C(C), .V(V),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: present an op and hold it until accepted (bounded)
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctr);
    int waited;
    A = a; B = b; CTR = ctr; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 40) begin
      @(posedge ck); #1;
      waited++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge ck); #1;
    in_valid = 1'b0;
  endtask

  // counts edges from the accept edge to out_valid; flags any in_ready while busy
  task automatic wait_result(output int lat, output bit busy_ready);
    lat = 0;
    busy_ready = in_ready;
    do begin
      @(posedge ck); #1;
      lat++;
      if (!out_valid && in_ready) busy_ready = 1'b1;
    end while (!out_valid && lat < 40);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] ctr, input logic [W-1:0] exp_o,
                        input logic [3:0] exp_f, input int exp_lat);
    int lat;
    bit busy_ready;
    send(a, b, ctr);
    wait_result(lat, busy_ready);
    check({tag, "_ovalid"}, 32'(out_valid), 32'd1);
    check({tag, "_o"}, 32'(O), 32'(exp_o));
    check({tag, "_zncv"}, 32'({Z, N, C, V}), 32'(exp_f));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; CTR = '0;
    repeat (2) @(posedge ck);
    #1;
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_o", 32'(O), 32'd0);
    check("rst_flags", 32'({Z, N, C, V}), 32'd0);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);

    // arithmetic chain with carry state
    run_op("add_ff_01",  8'hFF, 8'h01, 4'b0000, 8'h00, 4'b1010, 1);
    run_op("adc_10_20",  8'h10, 8'h20, 4'b0010, 8'h31, 4'b0000, 1);
    run_op("sub_80_01",  8'h80, 8'h01, 4'b0001, 8'h7F, 4'b0001, 1);
    run_op("sub_01_02",  8'h01, 8'h02, 4'b0001, 8'hFF, 4'b0110, 1);
    run_op("mul_0d_0b",  8'h0D, 8'h0B, 4'b0011, 8'h8F, 4'b0100, 9);
    run_op("mul_20_10",  8'h20, 8'h10, 4'b0011, 8'h00, 4'b1010, 9);
    run_op("adc_cin",    8'h01, 8'h01, 4'b0010, 8'h03, 4'b0000, 1);
    run_op("and",        8'hF0, 8'h3C, 4'b1000, 8'h30, 4'b0000, 1);
    run_op("or",         8'hF0, 8'h0F, 4'b1001, 8'hFF, 4'b0100, 1);
    run_op("xor",        8'hAA, 8'hFF, 4'b1010, 8'h55, 4'b0000, 1);
    run_op("not",        8'h00, 8'h00, 4'b1011, 8'hFF, 4'b0100, 1);
    run_op("shr",        8'h81, 8'h00, 4'b1100, 8'h40, 4'b0010, 1);
    run_op("shl",        8'h81, 8'h00, 4'b1101, 8'h02, 4'b0010, 1);
    run_op("ror",        8'h01, 8'h00, 4'b1110, 8'h80, 4'b0110, 1);
    run_op("reserved",   8'hFF, 8'hFF, 4'b0101, 8'h00, 4'b0000, 1);

    // backpressure: drain the last result, then stall the consumer
    @(posedge ck); #1;
    out_ready = 1'b0;
    run_op("rol_81",     8'h81, 8'h00, 4'b1111, 8'h03, 4'b0010, 1);
    for (int i = 0; i < 3; i++) begin
      A = 8'(i + 1); B = 8'h01; CTR = 4'b0000; in_valid = 1'b1;
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge ck); #1;
      check("bp_o_held", 32'(O), 32'h03);
      check("bp_ovalid_held", 32'(out_valid), 32'd1);
    end
    A = 8'h05; B = 8'h06; CTR = 4'b0000; out_ready = 1'b1;
    #1;
    check("drain_in_ready", 32'(in_ready), 32'd1);
    @(posedge ck); #1;
    in_valid = 1'b0;
    check("drain_ovalid", 32'(out_valid), 32'd0);
    check("drain_state", 32'(dbg_state), 32'd1);
    @(posedge ck); #1;
    check("drain_new_ovalid", 32'(out_valid), 32'd1);
    check("drain_new_o", 32'(O), 32'h0B);
    check("drain_new_zncv", 32'({Z, N, C, V}), 32'd0);

    // reset in the middle of a multiply, with carry state set beforehand
    run_op("add_set_c",  8'hFF, 8'h01, 4'b0000, 8'h00, 4'b1010, 1);
    send(8'h0D, 8'h0B, 4'b0011);
    repeat (5) begin
      @(posedge ck); #1;
    end
    check("mid_mul_state", 32'(dbg_state), 32'd2);
    check("mid_mul_ovalid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    @(posedge ck); #1;
    rst_n = 1'b1;
    #1;
    check("abort_ovalid", 32'(out_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_o", 32'(O), 32'd0);
    repeat (12) begin
      @(posedge ck); #1;
      if (out_valid) check("abort_late_ovalid", 32'(out_valid), 32'd0);
    end
    run_op("adc_after_rst", 8'h01, 8'h01, 4'b0010, 8'h02, 4'b0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
